pixel_frame_loader: RTL and testbench
=====================================

// Module: pixel_frame_loader
// PURPOSE
//  Upstream feeder for the perceptron classifier. Accepts a binary 5x5 image one pixel per beat
//  over a valid/ready stream and assembles it into a WIDTH-bit shadow register. It then publishes
//  the frame on a stable WIDTH-bit bus and holds it long enough for the free-running perceptron
//  sweep to finish one full, aligned evaluation. Double-buffered: the next frame fills during the hold.
// PARAMETERS
//  WIDTH        25            pixels per frame (row-major, top-left = bit 0)
//  HOLD_CYCLES  2*WIDTH+1     cycles frame_en stays high per frame; >= 2*(WIDTH+1)-1 guarantees one complete sweep at any phase
// PORTS
//  clk          in   1                  single clock, rising edge
//  rst_n        in   1                  asynchronous, active-low reset
//  pix_valid    in   1                  pixel beat valid
//  pix_sof      in   1                  qualifies beat as first pixel of a frame
//  pix_data     in   1                  pixel value (1 = set)
//  pix_ready    out  1                  loader can accept a beat; = !shadow_full
//  frame_out    out  WIDTH              published frame -> perceptron `in`
//  frame_en     out  1                  high while frame_out is in its hold window -> perceptron `en`
//  frame_stb    out  1                  one-cycle pulse in the first cycle of each new publish
//  err_cnt      out  8                  aborted-frame count; port exists only with PIXLOAD_ERR_CNT_EN
// BEHAVIOUR
//  Reset (async, rst_n=0): frame_out=0, frame_en=0, frame_stb=0, shadow=0, idx=0, shadow_full=0
//   (so pix_ready=1), hold_cnt=0, err_cnt=0. Reset mid-fill or mid-hold discards all data immediately.
//  Accept = pix_valid & pix_ready. On accept: shadow[idx] <= pix_data; idx <= idx+1.
//   idx is $clog2(WIDTH+1) bits wide. With pix_sof=1 on an accept, the beat writes bit 0 and idx <= 1,
//   restarting the frame (any partial frame is discarded).
//  When the accept writes bit WIDTH-1: shadow_full <= 1, idx <= 0. pix_ready drops the next cycle.
//  Beats presented while pix_ready=0 are not accepted and have no effect, including pix_sof.
//  The shadow is not cleared between frames; every bit is rewritten before shadow_full sets.
//  Output FSM, 2 states:
//   IDLE: frame_en=0. If shadow_full: frame_out <= shadow, frame_stb <= 1, shadow_full <= 0,
//     hold_cnt <= HOLD_CYCLES-1, go to HOLD. Latency from the last-pixel accept edge to frame_en=1 is
//     one clock.
//   HOLD: frame_en=1 and frame_out is constant. hold_cnt decrements each cycle.
//     When hold_cnt==0 and shadow_full: republish back-to-back. frame_out <= shadow, frame_stb pulses,
//       hold_cnt reloads, frame_en stays 1, shadow_full clears.
//     When hold_cnt==0 and !shadow_full: go to IDLE, frame_en <= 0. frame_out keeps its last value.
//  Simultaneous: if the last-pixel accept and hold_cnt==0 fall in the same cycle, shadow_full is not
//   yet set, so the FSM goes to IDLE and publishes on the following edge. The gap is exactly one
//   cycle with frame_en=0.
//  Throughput: during HOLD the loader accepts up to WIDTH beats. It then stalls (pix_ready=0) until
//   the republish.
// CONFIGURATION
//  PIXLOAD_ERR_CNT_EN defined: adds the err_cnt port, an 8-bit saturating count (sticks at 255).
//   It increments on each accepted pix_sof beat while idx != 0, i.e. each aborted partial frame.
//   A pix_sof at idx==0 is normal and does not count.
//  PIXLOAD_ERR_CNT_EN undefined: the port and the counter are absent. Frame restart behaviour is identical.
// STRUCTURE
//  Shared package gusn_pkg: IMG_ROWS=5, IMG_COLS=5, FRAME_WIDTH=IMG_ROWS*IMG_COLS,
//   class codes CLS_NONE=2'b00, CLS_A=2'b01, CLS_B=2'b10, loader state enum {LD_IDLE, LD_HOLD}.
//  One sub-module, pixload_hold_timer: loadable down-counter with an hold_cnt==0 flag, parameterised
//   by HOLD_CYCLES. Fill logic and the FSM stay in the top module.
// TESTING
//  1 Reset, then stream 25 beats with pix_sof on beat 0 and a cross pattern (1 at bits 0,4,12,20,24)
//    -> frame_stb one clock after the last accept; frame_out=25'h1101011; frame_en high exactly 51 cycles.
//  2 Feed frame B immediately after frame A's publish -> pix_ready=0 after 25 beats; back-to-back
//    republish at A's hold end with frame_en continuously 1 and one frame_stb pulse.
//  3 pix_sof on beat 10 of a frame, then 25 clean beats -> only the clean frame is published;
//    with PIXLOAD_ERR_CNT_EN err_cnt=1.
//  4 Last-pixel accept in the same cycle as hold_cnt==0 -> frame_en low for exactly one cycle, then
//    the new publish.
//  5 rst_n low for 1 cycle mid-HOLD and again at idx=12 -> outputs 0 asynchronously, pix_ready=1;
//    a new full frame publishes normally.
//  6 Force err_cnt to 255 via 256 aborts -> err_cnt stays 255.

Source files
------------

// File: rtl/gusn_pkg.sv
// Shared constants and types for the perceptron image path.
// Holds frame geometry, class codes and loader FSM states.
package gusn_pkg;

    localparam int IMG_ROWS    = 5;
    localparam int IMG_COLS    = 5;
    localparam int FRAME_WIDTH = IMG_ROWS * IMG_COLS;

    typedef enum logic [1:0] {
        CLS_NONE = 2'b00,
        CLS_A    = 2'b01,
        CLS_B    = 2'b10
    } cls_t;

    typedef enum logic {
        LD_IDLE,
        LD_HOLD
    } ld_state_t;

endpackage

// File: rtl/pixload_hold_timer.sv
// Loadable down-counter timing the frame hold window.
// zero is high once the count has run out (and while idle).
module pixload_hold_timer
    import gusn_pkg::*;
#(
    parameter int HOLD_CYCLES = 2 * FRAME_WIDTH + 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    output logic zero
);

    localparam int CW = $clog2(HOLD_CYCLES + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= CW'(HOLD_CYCLES - 1);
        end else if (cnt != '0) begin
            cnt <= cnt - CW'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/pixel_frame_loader.sv
// Streams a binary frame into a shadow register and publishes it for a hold window.
// Optional PIXLOAD_ERR_CNT_EN adds a saturating aborted-frame counter (err_cnt).
module pixel_frame_loader
    import gusn_pkg::*;
#(
    parameter int WIDTH       = FRAME_WIDTH,
    parameter int HOLD_CYCLES = 2 * WIDTH + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pix_valid,
    input  logic             pix_sof,
    input  logic             pix_data,
    output logic             pix_ready,
    output logic [WIDTH-1:0] frame_out,
    output logic             frame_en,
    output logic             frame_stb
`ifdef PIXLOAD_ERR_CNT_EN
    ,
    output logic [7:0]       err_cnt
`endif
);

    localparam int IW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] shadow;
    logic [IW-1:0]    idx;
    logic [IW-1:0]    widx;
    logic             shadow_full;
    logic             accept;
    logic             last;
    logic             hold_zero;
    logic             publish;
    ld_state_t        state;
    ld_state_t        state_d;

    assign pix_ready = !shadow_full;
    assign accept    = pix_valid & pix_ready;
    assign widx      = pix_sof ? '0 : idx;
    assign last      = (widx == IW'(WIDTH - 1));
    assign frame_en  = (state == LD_HOLD);

    // A start-of-frame beat restarts the fill at bit 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow      <= '0;
            idx         <= '0;
            shadow_full <= 1'b0;
        end else begin
            if (accept) begin
                shadow[widx] <= pix_data;
                idx          <= last ? '0 : widx + IW'(1);
            end
            if (publish) begin
                shadow_full <= 1'b0;
            end else if (accept && last) begin
                shadow_full <= 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state;
        publish = 1'b0;
        unique case (state)
            LD_IDLE: begin
                if (shadow_full) begin
                    publish = 1'b1;
                    state_d = LD_HOLD;
                end
            end
            LD_HOLD: begin
                if (hold_zero) begin
                    if (shadow_full) begin
                        publish = 1'b1;
                    end else begin
                        state_d = LD_IDLE;
                    end
                end
            end
            default: state_d = LD_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= LD_IDLE;
            frame_out <= '0;
            frame_stb <= 1'b0;
        end else begin
            state     <= state_d;
            frame_stb <= publish;
            if (publish) begin
                frame_out <= shadow;
            end
        end
    end

    pixload_hold_timer #(
        .HOLD_CYCLES(HOLD_CYCLES)
    ) u_timer (
        .clk  (clk),
        .rst_n(rst_n),
        .load (publish),
        .zero (hold_zero)
    );

`ifdef PIXLOAD_ERR_CNT_EN
    // Counts restarts of a partially filled frame, saturating at 255.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if (accept && pix_sof && idx != '0 && err_cnt != 8'hFF) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pixel_frame_loader.sv
// Scoreboard bench for pixel_frame_loader: expected frames are queued at
// stimulus time and checked by a monitor on every frame_stb pulse.
module tb_pixel_frame_loader;

    localparam int W = 25;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         pix_valid = 1'b0;
    logic         pix_sof = 1'b0;
    logic         pix_data = 1'b0;
    logic         pix_ready;
    logic [W-1:0] frame_out;
    logic         frame_en;
    logic         frame_stb;
`ifdef PIXLOAD_ERR_CNT_EN
    logic [7:0]   err_cnt;
`endif

    int checks = 0;
    int errors = 0;

    logic [W-1:0] exp_q[$];

    int en_run = 0;
    int run_stbs = 0;
    int last_run = 0;
    int last_stbs = 0;

    always #5 clk = ~clk;

    pixel_frame_loader dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .pix_valid(pix_valid),
        .pix_sof  (pix_sof),
        .pix_data (pix_data),
        .pix_ready(pix_ready),
        .frame_out(frame_out),
        .frame_en (frame_en),
        .frame_stb(frame_stb)
`ifdef PIXLOAD_ERR_CNT_EN
        ,
        .err_cnt  (err_cnt)
`endif
    );

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
    endtask

    task automatic tmo(input string n);
        checks++;
        errors++;
        $display("FAIL %s: timeout", n);
    endtask

    // Monitor: pops the scoreboard on each publish and tracks frame_en runs.
    always @(negedge clk) begin
        if (frame_stb) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: got frame %0h expected none", frame_out);
            end else begin
                chk("sb_frame", 32'(frame_out), 32'(exp_q.pop_front()));
            end
            chk("sb_en_with_stb", 32'(frame_en), 32'd1);
        end
        if (frame_en) begin
            en_run++;
            if (frame_stb) run_stbs++;
        end else begin
            if (en_run > 0) begin
                last_run  = en_run;
                last_stbs = run_stbs;
            end
            en_run   = 0;
            run_stbs = 0;
        end
    end

    task automatic send(input logic d, input logic s);
        bit r;
        int n;
        n = 0;
        pix_valid = 1'b1;
        pix_data  = d;
        pix_sof   = s;
        do begin
            @(negedge clk);
            r = pix_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!r && n < 500);
        if (!r) tmo("send_accept");
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
    endtask

    task automatic send_frame(input logic [W-1:0] f);
        for (int i = 0; i < W; i++) send(f[i], i == 0);
    endtask

    task automatic wait_stb();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (frame_stb) return;
        end
        tmo("wait_stb");
    endtask

    task automatic wait_en_low();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!frame_en) begin
                @(posedge clk);
                #1;
                return;
            end
        end
        tmo("wait_en_low");
    endtask

    task automatic pulse_reset();
        #3 rst_n = 1'b0;
        #1;
        chk("rst_frame_out", 32'(frame_out), 32'd0);
        chk("rst_frame_en", 32'(frame_en), 32'd0);
        chk("rst_frame_stb", 32'(frame_stb), 32'd0);
        chk("rst_pix_ready", 32'(pix_ready), 32'd1);
`ifdef PIXLOAD_ERR_CNT_EN
        chk("rst_err_cnt", 32'(err_cnt), 32'd0);
`endif
        @(posedge clk);
        #3 rst_n = 1'b1;
        exp_q.delete();
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("init_frame_out", 32'(frame_out), 32'd0);
        chk("init_frame_en", 32'(frame_en), 32'd0);
        chk("init_frame_stb", 32'(frame_stb), 32'd0);
        chk("init_pix_ready", 32'(pix_ready), 32'd1);
        #2 rst_n = 1'b1;

        // 1: cross pattern, one-clock latency, 51-cycle hold
        exp_q.push_back(25'h1101011);
        send_frame(25'h1101011);
        @(negedge clk);
        chk("t1_stb_not_yet", 32'(frame_stb), 32'd0);
        @(negedge clk);
        chk("t1_stb_next_clk", 32'(frame_stb), 32'd1);
        chk("t1_frame_out", 32'(frame_out), 32'h1101011);
        wait_en_low();
        chk("t1_hold_len", 32'(last_run), 32'd51);

        // 2: back-to-back republish
        exp_q.push_back(25'h1555555);
        send_frame(25'h1555555);
        exp_q.push_back(25'h0ABCDEF);
        send_frame(25'h0ABCDEF);
        @(negedge clk);
        chk("t2_ready_low", 32'(pix_ready), 32'd0);
        chk("t2_en_during_fill", 32'(frame_en), 32'd1);
        wait_en_low();
        chk("t2_run_len", 32'(last_run), 32'd102);
        chk("t2_run_stbs", 32'(last_stbs), 32'd2);

        // 3: restart on beat 10
        for (int i = 0; i < 10; i++) send(1'b1, i == 0);
        exp_q.push_back(25'h00F00F0);
        send_frame(25'h00F00F0);
        wait_stb();
        wait_en_low();
        chk("t3_run_stbs", 32'(last_stbs), 32'd1);
        chk("t3_run_len", 32'(last_run), 32'd51);
`ifdef PIXLOAD_ERR_CNT_EN
        chk("t3_err_cnt", 32'(err_cnt), 32'd1);
`endif

        // 4: last accept coincides with hold expiry
        exp_q.push_back(25'h1FFFFFF);
        send_frame(25'h1FFFFFF);
        wait_stb();
        repeat (26) @(posedge clk);
        #1;
        exp_q.push_back(25'h0123456);
        send_frame(25'h0123456);
        @(negedge clk);
        chk("t4_gap_en", 32'(frame_en), 32'd0);
        @(negedge clk);
        chk("t4_after_gap_en", 32'(frame_en), 32'd1);
        chk("t4_after_gap_stb", 32'(frame_stb), 32'd1);
        wait_en_low();
        chk("t4_run_len", 32'(last_run), 32'd51);

        // 5: reset mid-hold and mid-fill
        exp_q.push_back(25'h1E0000F);
        send_frame(25'h1E0000F);
        wait_stb();
        repeat (5) @(posedge clk);
        pulse_reset();
        for (int i = 0; i < 12; i++) send(1'b1, i == 0);
        pulse_reset();
        exp_q.push_back(25'h0000001);
        send_frame(25'h0000001);
        wait_stb();
        wait_en_low();
        chk("t5_run_len", 32'(last_run), 32'd51);
        chk("t5_queue_empty", 32'(exp_q.size()), 32'd0);

`ifdef PIXLOAD_ERR_CNT_EN
        // 6: saturation
        send(1'b0, 1'b1);
        repeat (255) send(1'b0, 1'b1);
        chk("t6_err_255", 32'(err_cnt), 32'd255);
        send(1'b0, 1'b1);
        chk("t6_err_sticks", 32'(err_cnt), 32'd255);
`endif

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
